// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared types and constants for the data-memory responder.
//   mem_size_e       : access size encoding on the `size` port (2'b11 is treated as word)
//   dmem_state_e     : responder FSM states
//   DMEM_MAX_LATENCY : largest supported request-to-ready latency
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  localparam int DMEM_MAX_LATENCY = 15;

endpackage

// File: rtl/dmem_byte_mask.sv
// dmem_byte_mask
// Combinational lane decoder: turns an access size and the low two address
// bits into a 4-bit byte-lane write mask plus a misalignment flag.
//   size_i     : access size (byte/half/word, 2'b11 treated as word)
//   addr_lo_i  : addr[1:0] of the access
//   mask_o     : byte lanes touched by the access (bit n = byte lane n)
//   misalign_o : half with addr[0]=1, or word with addr[1:0]!=0
// Misaligned accesses still get a forced-aligned mask; the caller decides
// whether the flag turns into an error.
module dmem_byte_mask
  import dmem_responder_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] mask_o,
  output logic       misalign_o
);

  // Lane mask and alignment decode.
  always_comb begin
    mask_o     = 4'b0000;
    misalign_o = 1'b0;
    case (size_i)
      MEM_BYTE: begin
        mask_o     = 4'b0001 << addr_lo_i;
        misalign_o = 1'b0;
      end
      MEM_HALF: begin
        // addr[0] is ignored for lane selection: lanes {addr[1],0} and {addr[1],1}
        if (addr_lo_i[1]) begin
          mask_o = 4'b1100;
        end else begin
          mask_o = 4'b0011;
        end
        misalign_o = addr_lo_i[0];
      end
      default: begin
        // MEM_WORD and the 2'b11 encoding both access the full word
        mask_o     = 4'b1111;
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Slave end of the core data-memory interface. Accepts one outstanding
// read/write, holds it for LATENCY cycles, then pulses `ready` for one cycle
// with read data. Word-organised storage with byte/half/word write lanes.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   req    : request valid, held by the master until ready
//   wr     : 1 = write, 0 = read
//   addr   : byte address (upper bits wrap modulo DEPTH*4)
//   wdata  : lane-aligned write data
//   size   : 00 byte, 01 half, 10 word, 11 word
//   rdata  : read data, held until the next read response
//   ready  : one-cycle response pulse
//   err    : error flag, valid with ready
//
// Optional feature macro: DMEM_ERR_CHECK_EN
//   defined   : misaligned or out-of-range accesses respond with err=1,
//               suppressed write and rdata=0
//   undefined : err tied 0, alignment forced, out-of-range addresses wrap
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    size,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          err
);

  localparam int         IDXW   = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  // Latched request; inputs are ignored once accepted
  logic [AW-1:0]   addr_q;
  logic            wr_q;
  logic [DW-1:0]   wdata_q;
  logic [1:0]      size_q;

  logic            accept_s;
  logic            commit_s;
  logic [3:0]      mask_s;
  logic            misalign_s;
  logic            err_s;
  logic [IDXW-1:0] idx_s;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   rdata_q;
  logic            ready_q;
  logic            err_q;

  assign idx_s = addr_q[IDXW+1:2];

  dmem_byte_mask u_mask (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .mask_o     (mask_s),
    .misalign_o (misalign_s)
  );

`ifdef DMEM_ERR_CHECK_EN
  assign err_s = misalign_s | (|addr_q[AW-1:IDXW+2]);
`else
  assign err_s = 1'b0;
  logic unused_s;
  assign unused_s = misalign_s ^ (^addr_q[AW-1:IDXW+2]);
`endif

  // Next-state logic: accept in IDLE, count down in WAIT, single RESP cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept_s = 1'b1;
          cnt_d    = LAT_M1;
          state_d  = WAIT;
        end else begin
          state_d  = IDLE;
        end
      end
      WAIT: begin
        // commit_s marks the edge entering RESP: write commit and read capture
        if (cnt_q == 4'd0) begin
          commit_s = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d    = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= {DW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit_s;
      err_q   <= commit_s & err_s;
      if (commit_s && err_s) begin
        rdata_q <= {DW{1'b0}};
      end else if (commit_s && !wr_q) begin
        rdata_q <= mem_q[idx_s];
      end
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      addr_q  <= addr;
      wr_q    <= wr;
      wdata_q <= wdata;
      size_q  <= size;
    end
  end

  // Storage write: byte lanes committed on the edge entering RESP; reset
  // abandons the transaction so no commit happens while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && commit_s && wr_q && !err_s) begin
      for (int l = 0; l < 4; l++) begin
        if (mask_s[l]) begin
          mem_q[idx_s][8*l +: 8] <= wdata_q[8*l +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  dmem_responder #(.AW(32), .DW(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .size  (size),
    .rdata (rdata),
    .ready (ready),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model: byte-addressable view of the storage
  logic [31:0] mem_m   [DEPTH];
  logic [3:0]  known_m [DEPTH];
  logic [31:0] last_rd;
  bit          last_known;

  function automatic void expect_req(input bit w, input logic [31:0] a,
                                     input logic [31:0] d, input logic [1:0] s,
                                     input int due);
    exp_t e;
    int   wi;
    int   base;
    int   first;
    int   nbytes;
    bit   mis;
    bit   oor;
    bit   bad;
    wi   = int'((a / 32'd4) % DEPTH);
    base = int'(a % 32'd4);
    if (s == 2'd0) begin
      first = base; nbytes = 1; mis = 1'b0;
    end else if (s == 2'd1) begin
      first = (base / 2) * 2; nbytes = 2; mis = (base % 2) != 0;
    end else begin
      first = 0; nbytes = 4; mis = base != 0;
    end
    oor = a >= 32'(DEPTH * 4);
    bad = ERRCHK && (mis || oor);
    if (bad) begin
      last_rd = 32'd0; last_known = 1'b1;
    end else if (w) begin
      for (int l = first; l < first + nbytes; l++) begin
        mem_m[wi][8*l +: 8] = d[8*l +: 8];
        known_m[wi][l] = 1'b1;
      end
    end else begin
      last_rd = mem_m[wi];
      last_known = (known_m[wi] == 4'hF);
    end
    e.rdata = last_rd;
    e.chk_rdata = last_known;
    e.err = bad;
    e.cyc = due;
    sb.push_back(e);
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation
  exp_t m;
  always @(negedge clk) begin
    if (rst_n && ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ready at cycle %0d", cyc);
      end else begin
        m = sb.pop_front();
        checks++;
        if (cyc != m.cyc) begin
          errors++;
          $display("FAIL ready_timing got cycle %0d exp %0d", cyc, m.cyc);
        end
        checks++;
        if (err !== m.err) begin
          errors++;
          $display("FAIL err got %b exp %b (cycle %0d)", err, m.err, cyc);
        end
        if (m.chk_rdata) begin
          checks++;
          if (rdata !== m.rdata) begin
            errors++;
            $display("FAIL rdata got %h exp %h (cycle %0d)", rdata, m.rdata, cyc);
          end
        end
      end
    end
  end

  // Waits for ready; after acceptance the inputs are scrambled to prove the
  // latched copy is used. keep holds req high through ready.
  task automatic wait_ready(input bit keep, input int skip, output logic [31:0] rd,
                            output bit got);
    int n;
    n = 0; got = 1'b0; rd = 32'd0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ready) begin
        got = 1'b1;
        rd = rdata;
        if (!keep) req = 1'b0;
      end else if (n > skip) begin
        addr = $urandom; wdata = $urandom; wr = 1'($urandom); size = 2'($urandom);
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout after %0d cycles", n);
      req = 1'b0;
      sb.delete();
    end
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, output logic [31:0] rd);
    bit got;
    @(negedge clk);
    expect_req(w, a, d, s, cyc + 1 + LAT);
    req = 1'b1; wr = w; addr = a; wdata = d; size = s;
    wait_ready(1'b0, 0, rd, got);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  logic [31:0] rd;
  logic [31:0] a;
  bit          got;

  initial begin
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; size = 2'd0;
    for (int i = 0; i < DEPTH; i++) begin
      known_m[i] = 4'h0; mem_m[i] = 32'd0;
    end
    last_rd = 32'd0; last_known = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("reset_ready", {31'd0, ready}, 32'd0);
    check_val("reset_rdata", rdata, 32'd0);
    check_val("reset_err", {31'd0, err}, 32'd0);

    // Fill words 0..31 so later reads are fully predictable
    for (int i = 0; i < 32; i++) issue(1'b1, 32'(i * 4), $urandom, 2'b10, rd);

    // Word write then read
    issue(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, rd);
    issue(1'b0, 32'h10, 32'h0, 2'b10, rd);
    check_val("word_rw", rd, 32'hDEADBEEF);

    // Byte and half lanes over an existing word
    issue(1'b1, 32'h20, 32'h11223344, 2'b10, rd);
    issue(1'b1, 32'h21, 32'h0000AA00, 2'b00, rd);
    issue(1'b1, 32'h22, 32'h55660000, 2'b01, rd);
    issue(1'b0, 32'h20, 32'h0, 2'b10, rd);
    check_val("lane_merge", rd, 32'h5566AA44);

    // req held through ready: next request accepted in the IDLE cycle after RESP
    @(negedge clk);
    expect_req(1'b1, 32'h40, 32'h0BADF00D, 2'b10, cyc + 1 + LAT);
    req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'h0BADF00D; size = 2'b10;
    wait_ready(1'b1, 0, rd, got);
    if (got) begin
      expect_req(1'b0, 32'h40, 32'h0, 2'b10, cyc + 2 + LAT);
      wr = 1'b0; addr = 32'h40; wdata = 32'h0; size = 2'b10;
      wait_ready(1'b0, 1, rd, got);
      check_val("back_to_back_read", rd, 32'h0BADF00D);
    end else begin
      req = 1'b0;
    end

    // Reset during WAIT abandons the write
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; size = 2'b10;
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("no_ready_in_reset", {31'd0, ready}, 32'd0);
    end
    rst_n = 1'b1;
    last_rd = 32'd0; last_known = 1'b1;
    @(negedge clk);
    check_val("rdata_after_reset", rdata, 32'd0);
    issue(1'b0, 32'h30, 32'h0, 2'b10, rd);
    check_val("abandoned_write", rd, mem_m[12]);

    // Misaligned half write and out-of-range read
    issue(1'b1, 32'h31, 32'h0000BEEF, 2'b01, rd);
    issue(1'b0, 32'h30, 32'h0, 2'b10, rd);
    issue(1'b0, 32'(DEPTH * 4), 32'h0, 2'b10, rd);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      issue(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)), rd);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
